forwarding_hazard_unit: RTL
===========================

# forwarding_hazard_unit

Parametrised operand-forwarding and load-use hazard unit for the pipelined core, placed alongside the EXE stage. Forwards results for N_SRC operand ports from MEM or WB, with MEM-over-WB priority, and never forwards a load result from MEM. Detects load-use hazards between the load in EXE and the sources in ID, and runs a counted stall/bubble sequence of LOAD_LAT cycles. Keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- REG_W, 5, register index width
- N_SRC, 3, number of operand ports (e.g. ALU A, ALU B, store data); 1..8
- LOAD_LAT, 1, bubbles per load-use hazard; 1..8
- ZERO_REG, 1, if 1 register index 0 is never forwarded and never causes a hazard

- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- src_EXE  in  N_SRC*REG_W  packed source indices in EXE; port i = [i*REG_W +: REG_W]
- src_valid_EXE  in  N_SRC  port i actually read in EXE
- src_ID  in  N_SRC*REG_W  packed source indices in ID
- src_valid_ID  in  N_SRC  port i actually read in ID
- dest_EXE, dest_MEM, dest_WB  in  REG_W each  destination index per stage
- WB_EN_EXE, WB_EN_MEM, WB_EN_WB  in  1 each  stage writes register file
- MEM_RD_EXE, MEM_RD_MEM  in  1 each  instruction in that stage is a load
- flush  in  1  branch/exception flush, synchronous
- fwd_sel  out  2*N_SRC  port i = [2i +: 2]: 0 decode, 1 MEM, 2 WB; 3 never driven
- stall_IF, stall_ID  out  1 each  hold PC and the IF/ID register
- bubble_EXE  out  1  load NOP into the ID/EXE register
- hazard_cnt  out  16  saturating count of hazard stall cycles

## Operation
- Match definitions:
  - match(x, d) = (x == d) && !(ZERO_REG && x == 0).
  - Port i MEM hit: src_valid_EXE[i] && WB_EN_MEM && !MEM_RD_MEM && match(src_i, dest_MEM).
  - Port i WB hit: src_valid_EXE[i] && WB_EN_WB && match(src_i, dest_WB).
- fwd_sel per port (combinational): MEM hit -> 1, else WB hit -> 2, else 0. Ports are independent.
- hazard (combinational): MEM_RD_EXE && WB_EN_EXE && any i with src_valid_ID[i] && match(srcID_i, dest_EXE).
- FSM states and transitions:
  - IDLE: stall_o = hazard && !flush.
    - If stall_o and LOAD_LAT > 1: go to STALL, cnt <= LOAD_LAT-1.
    - Otherwise stay in IDLE.
  - STALL: stall_o = !flush; hazard is ignored.
    - flush: go to IDLE, cnt <= 0.
    - cnt == 1: go to IDLE.
    - Otherwise cnt <= cnt-1.
- stall_IF = stall_ID = bubble_EXE = stall_o.
- hazard_cnt: increments by 1 on every cycle where stall_o = 1; holds at 16'hFFFF (saturates, no wrap).
- cnt width: $clog2(LOAD_LAT+1).

## Timing
- Reset (rst_n low, asynchronous):
  - State IDLE, cnt = 0, hazard_cnt = 0.
  - stall_IF, stall_ID, bubble_EXE = 0; fwd_sel = 0 on all ports.
  - Outputs stay at these values while rst_n is low.
- fwd_sel has zero latency, purely combinational from current inputs.
- stall_o is Mealy:
  - Asserted in the same cycle the hazard is presented (cycle t).
  - Stays high exactly LOAD_LAT consecutive cycles, t..t+LOAD_LAT-1.
  - Low at t+LOAD_LAT, which is the IDLE re-evaluation cycle.
- Hazards are not detected while in STALL; EXE holds the inserted bubble.
- Back-to-back hazards: a new hazard seen at t+LOAD_LAT starts a new sequence with no gap cycle.
- flush has priority over everything:
  - stall_o is 0 in the flush cycle.
  - FSM is in IDLE on the next cycle.
  - hazard_cnt does not count the flush cycle.
- Reset asserted mid-STALL: outputs drop immediately; the next sequence starts from IDLE.
- Load-to-use distance when LOAD_LAT = 1: the consumer reaches EXE while the load is in WB and receives fwd_sel = 2.

## Test plan
- MEM-over-WB priority: port0 src 3, dest_MEM = dest_WB = 3, both WB_EN set -> fwd_sel[1:0] = 1. Clear WB_EN_MEM -> 2. Clear src_valid_EXE[0] -> 0.
- Load in MEM not forwarded: port1 src 7, dest_MEM = 7 with MEM_RD_MEM = 1, dest_WB = 7 with WB_EN_WB = 1 -> fwd_sel[3:2] = 2.
- Zero register: ZERO_REG = 1, src 0 everywhere with a matching load in EXE -> fwd_sel = 0, no stall. With ZERO_REG = 0 the same stimulus forwards and stalls.
- Load-use, LOAD_LAT = 1: load dest 5 in EXE, ID port2 src 5 -> stall_IF/ID and bubble_EXE high exactly 1 cycle, hazard_cnt = 1. Next cycle, WB dest 5 -> fwd_sel[5:4] = 2.
- LOAD_LAT = 3:
  - Hazard -> stall high 3 cycles, hazard_cnt = 3.
  - Repeat with flush in the 2nd stall cycle -> stall low that cycle, IDLE next, hazard_cnt = 1.
- Reset and saturation:
  - rst_n pulsed low mid-STALL -> outputs 0 asynchronously, hazard_cnt = 0.
  - Force 65540 stall cycles -> hazard_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding from MEM/WB and load-use stall sequencing for the EXE stage.
// Also keeps a saturating count of cycles spent stalling on load-use hazards.
module forwarding_hazard_unit #(
  parameter int REG_W    = 5,
  parameter int N_SRC    = 3,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_SRC*REG_W-1:0]   src_EXE,
  input  logic [N_SRC-1:0]         src_valid_EXE,
  input  logic [N_SRC*REG_W-1:0]   src_ID,
  input  logic [N_SRC-1:0]         src_valid_ID,
  input  logic [REG_W-1:0]         dest_EXE,
  input  logic [REG_W-1:0]         dest_MEM,
  input  logic [REG_W-1:0]         dest_WB,
  input  logic                     WB_EN_EXE,
  input  logic                     WB_EN_MEM,
  input  logic                     WB_EN_WB,
  input  logic                     MEM_RD_EXE,
  input  logic                     MEM_RD_MEM,
  input  logic                     flush,
  output logic [2*N_SRC-1:0]       fwd_sel,
  output logic                     stall_IF,
  output logic                     stall_ID,
  output logic                     bubble_EXE,
  output logic [15:0]              hazard_cnt
);

  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        hazard_cnt_q, hazard_cnt_d;
  logic [2*N_SRC-1:0] fwd_sel_s;
  logic               hazard_s;
  logic               stall_s;
  logic               stall_o_s;

  function automatic logic reg_match(input logic [REG_W-1:0] x, input logic [REG_W-1:0] d);
    return (x == d) && !((ZERO_REG != 0) && (x == {REG_W{1'b0}}));
  endfunction

  // Per-port forwarding select; a load still in MEM has no data to forward yet.
  always_comb begin
    fwd_sel_s = {(2*N_SRC){1'b0}};
    for (int i = 0; i < N_SRC; i++) begin
      if (!rst_n || !src_valid_EXE[i]) begin
        fwd_sel_s[2*i +: 2] = 2'd0;
      end else if (WB_EN_MEM && !MEM_RD_MEM && reg_match(src_EXE[i*REG_W +: REG_W], dest_MEM)) begin
        fwd_sel_s[2*i +: 2] = 2'd1;
      end else if (WB_EN_WB && reg_match(src_EXE[i*REG_W +: REG_W], dest_WB)) begin
        fwd_sel_s[2*i +: 2] = 2'd2;
      end else begin
        fwd_sel_s[2*i +: 2] = 2'd0;
      end
    end
  end

  // Load in EXE whose destination is read by any active ID source.
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (MEM_RD_EXE && WB_EN_EXE && src_valid_ID[i] && reg_match(src_ID[i*REG_W +: REG_W], dest_EXE)) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  // Stall sequencer next-state; the stall output is Mealy and flush always wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall_s = hazard_s && !flush;
        if (stall_s && (LOAD_LAT > 1)) begin
          state_d = ST_STALL;
          cnt_d   = CNT_W'(LOAD_LAT - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STALL: begin
        stall_s = !flush;
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        stall_s = 1'b0;
      end
    endcase
    stall_o_s = stall_s && rst_n;
    if (stall_o_s && (hazard_cnt_q != 16'hFFFF)) begin
      hazard_cnt_d = hazard_cnt_q + 16'd1;
    end else begin
      hazard_cnt_d = hazard_cnt_q;
    end
  end

  // State, down-counter and performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      hazard_cnt_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hazard_cnt_q <= hazard_cnt_d;
    end
  end

  assign fwd_sel    = fwd_sel_s;
  assign stall_IF   = stall_o_s;
  assign stall_ID   = stall_o_s;
  assign bubble_EXE = stall_o_s;
  assign hazard_cnt = hazard_cnt_q;

endmodule
